// File: rtl/crc_stream_pkg.sv
// crc_stream_pkg: shared types, width limits and helpers for the crc_stream
// CRC engine and its per-byte step.
//   state_t        frame FSM state (ACC accumulating/idle, HOLD result presented)
//   bit_reverse    reverses the low w bits of a value (upper bits return 0)
//   keep_legal     checks a beat's keep mask: full on non-last beats,
//                  LSB-contiguous (including all-zero) on the last beat
package crc_stream_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int unsigned MIN_DATA_W = 8;
  localparam int unsigned MAX_DATA_W = 128;
  localparam int unsigned MIN_POLY_W = 8;
  localparam int unsigned MAX_POLY_W = 64;
  localparam int unsigned MAX_BYTES  = MAX_DATA_W / 8;

  function automatic logic [MAX_POLY_W-1:0] bit_reverse(
    input logic [MAX_POLY_W-1:0] v,
    input int unsigned           w
  );
    logic [MAX_POLY_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_POLY_W; i++) begin
      if (i < w) r[i] = v[6'(w - 1 - i)];
    end
    return r;
  endfunction

  function automatic logic keep_legal(
    input logic [MAX_BYTES-1:0] keep,
    input int unsigned          nb,
    input logic                 last
  );
    logic [MAX_BYTES:0] full;
    logic [MAX_BYTES:0] k;
    full = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      full[i] = (i < nb);
    end
    k = {1'b0, keep} & full;
    if (!last) return (k == full);
    // A mask of the form 0..011..1 has no set bit above its lowest clear bit,
    // so adding one carries out of every set bit.
    return ((k & (k + 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/crc_stream_byte_step.sv
// crc_byte_step: combinational single-byte CRC update in normal (MSB-first)
// register form. With REFLECT set the input byte is bit-reversed first, which
// gives LSB-first processing while the register itself stays non-reflected.
//   crc_i   current CRC register (POLY_WIDTH bits)
//   data_i  byte to fold in
//   crc_o   CRC register after the byte
module crc_byte_step
  import crc_stream_pkg::*;
#(
  parameter int unsigned           POLY_WIDTH = 32,
  parameter logic [MAX_POLY_W-1:0] POLY       = 64'h0000_0000_04C1_1DB7,
  parameter logic                  REFLECT    = 1'b1
) (
  input  logic [POLY_WIDTH-1:0] crc_i,
  input  logic [7:0]            data_i,
  output logic [POLY_WIDTH-1:0] crc_o
);

  localparam logic [POLY_WIDTH-1:0] P = POLY[POLY_WIDTH-1:0];

  logic [7:0]            byte_rev;
  logic [7:0]            byte_in;
  logic [POLY_WIDTH-1:0] c;

  always_comb begin
    byte_rev = {<<{data_i}};
    byte_in  = REFLECT ? byte_rev : data_i;
    c        = crc_i ^ (POLY_WIDTH'(byte_in) << (POLY_WIDTH - 8));
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[POLY_WIDTH-1] ? ((c << 1) ^ P) : (c << 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/crc_stream.sv
// crc_stream: frame-based streaming CRC engine. Folds up to DATA_WIDTH/8 kept
// bytes per accepted beat into the CRC register and presents the finalised
// checksum on a held valid/ready output.
//   clk, rst            clock, synchronous active-high reset
//   s_data_i/s_keep_i   input beat (byte 0 first) and byte-valid mask
//   s_last_i/s_valid_i  end-of-frame marker and beat valid
//   s_ready_o           beat accepted when s_valid_i && s_ready_o
//   m_crc_o             final CRC (optionally reflected, XOR_OUT applied)
//   m_err_o             illegal keep pattern seen in the frame
//   m_valid_o/m_ready_i result handshake; outputs held until consumed
//   m_match_o           only with `define CRC_CHECK_EN: m_crc_o == RESIDUE
module crc_stream
  import crc_stream_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           POLY_WIDTH = 32,
  parameter logic [MAX_POLY_W-1:0] POLY       = 64'h0000_0000_04C1_1DB7,
  parameter logic [MAX_POLY_W-1:0] INIT       = 64'h0000_0000_FFFF_FFFF,
  parameter logic                  REFLECT    = 1'b1,
  parameter logic [MAX_POLY_W-1:0] XOR_OUT    = 64'h0000_0000_FFFF_FFFF,
  parameter logic [MAX_POLY_W-1:0] RESIDUE    = 64'h0000_0000_2144_DF1C
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_data_i,
  input  logic [DATA_WIDTH/8-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [POLY_WIDTH-1:0]   m_crc_o,
  output logic                    m_err_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
`ifdef CRC_CHECK_EN
  ,
  output logic                    m_match_o
`endif
);

  localparam int unsigned           NB     = DATA_WIDTH / 8;
  localparam logic [POLY_WIDTH-1:0] INIT_W = INIT[POLY_WIDTH-1:0];
  localparam logic [POLY_WIDTH-1:0] XOR_W  = XOR_OUT[POLY_WIDTH-1:0];

  state_t                state_q;
  logic [POLY_WIDTH-1:0] crc_q;
  logic                  err_q;
  logic [POLY_WIDTH-1:0] crc_next;
  logic                  err_next;
  logic [MAX_POLY_W-1:0] rev_full;
  logic [POLY_WIDTH-1:0] crc_final;

  // Unrolled byte chain: each stage either applies its byte or passes the
  // running CRC through unchanged when that byte's keep bit is clear.
  for (genvar k = 0; k < NB; k++) begin : g_byte
    logic [POLY_WIDTH-1:0] c_in;
    logic [POLY_WIDTH-1:0] stepped;
    logic [POLY_WIDTH-1:0] c_out;

    if (k == 0) begin : g_first
      assign c_in = crc_q;
    end else begin : g_next
      assign c_in = g_byte[k-1].c_out;
    end

    crc_byte_step #(
      .POLY_WIDTH(POLY_WIDTH),
      .POLY      (POLY),
      .REFLECT   (REFLECT)
    ) u_step (
      .crc_i (c_in),
      .data_i(s_data_i[8*k +: 8]),
      .crc_o (stepped)
    );

    assign c_out = s_keep_i[k] ? stepped : c_in;
  end

  assign crc_next  = g_byte[NB-1].c_out;
  assign err_next  = err_q | ~keep_legal(MAX_BYTES'(s_keep_i), NB, s_last_i);
  assign rev_full  = bit_reverse(MAX_POLY_W'(crc_next), POLY_WIDTH);
  assign crc_final = (REFLECT ? rev_full[POLY_WIDTH-1:0] : crc_next) ^ XOR_W;

  if (POLY_WIDTH < MAX_POLY_W) begin : g_rev_sink
    logic unused_rev_hi;
    assign unused_rev_hi = ^rev_full[MAX_POLY_W-1:POLY_WIDTH];
  end

  assign s_ready_o = (state_q == ACC) && !rst;
  assign m_valid_o = (state_q == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACC;
      crc_q     <= INIT_W;
      err_q     <= 1'b0;
      m_crc_o   <= '0;
      m_err_o   <= 1'b0;
`ifdef CRC_CHECK_EN
      m_match_o <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ACC: begin
          if (s_valid_i) begin
            crc_q <= crc_next;
            err_q <= err_next;
            if (s_last_i) begin
              state_q   <= HOLD;
              m_crc_o   <= crc_final;
              m_err_o   <= err_next;
`ifdef CRC_CHECK_EN
              m_match_o <= (crc_final == RESIDUE[POLY_WIDTH-1:0]);
`endif
            end
          end
        end
        HOLD: begin
          if (m_ready_i) begin
            state_q <= ACC;
            crc_q   <= INIT_W;
            err_q   <= 1'b0;
          end
        end
      endcase
    end
  end

`ifndef CRC_CHECK_EN
  logic unused_residue;
  assign unused_residue = ^RESIDUE;
`endif

endmodule

// File: tb/tb_crc_stream.sv
// tb_crc_stream: three crc_stream instances (CRC-32/32-bit beats,
// CRC-8/8-bit beats, CRC-16-CCITT-FALSE/32-bit beats). Drivers push expected
// results into per-instance queues; one monitor compares at every output
// presentation. Build with CRC_CHECK_EN to also check m_match_o.
module tb_crc_stream;

  typedef logic [31:0] wq_t[$];
  typedef logic [3:0]  kq_t[$];
  typedef logic [7:0]  bq_t[$];
  typedef struct {
    logic [31:0] crc;
    logic        err;
    logic        match;
    int          cyc;
  } exp_t;

  localparam int unsigned CW   [3] = '{32, 8, 16};
  localparam int unsigned CNB  [3] = '{4, 1, 4};
  localparam logic [63:0] CPOLY[3] = '{64'h04C11DB7, 64'h07, 64'h1021};
  localparam logic [63:0] CINIT[3] = '{64'hFFFFFFFF, 64'h0, 64'hFFFF};
  localparam logic        CREF [3] = '{1'b1, 1'b0, 1'b0};
  localparam logic [63:0] CXOR [3] = '{64'hFFFFFFFF, 64'h0, 64'h0};
  localparam logic [31:0] CRES [3] = '{32'h2144DF1C, 32'h1C, 32'hDF1C};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] sd [3];
  logic [3:0]  sk [3];
  logic        sl [3];
  logic        sv [3];
  logic        mr [3];
  logic        hold_low [3];
  logic        sr_v [3];
  logic        val_v [3];
  logic        err_v [3];
  logic [31:0] crc_v [3];
  logic [31:0] crc0;
  logic [7:0]  crc1;
  logic [15:0] crc2;
`ifdef CRC_CHECK_EN
  logic        mat_v [3];
`endif

  assign crc_v[0] = crc0;
  assign crc_v[1] = {24'h0, crc1};
  assign crc_v[2] = {16'h0, crc2};

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t expq [3][$];

  always @(posedge clk) cyc <= cyc + 1;

  crc_stream #(
    .DATA_WIDTH(32), .POLY_WIDTH(32), .POLY(64'h04C11DB7), .INIT(64'hFFFFFFFF),
    .REFLECT(1'b1), .XOR_OUT(64'hFFFFFFFF), .RESIDUE(64'h2144DF1C)
  ) u_dut0 (
    .clk(clk), .rst(rst), .s_data_i(sd[0]), .s_keep_i(sk[0]), .s_last_i(sl[0]),
    .s_valid_i(sv[0]), .s_ready_o(sr_v[0]), .m_crc_o(crc0), .m_err_o(err_v[0]),
    .m_valid_o(val_v[0]), .m_ready_i(mr[0])
`ifdef CRC_CHECK_EN
    , .m_match_o(mat_v[0])
`endif
  );

  crc_stream #(
    .DATA_WIDTH(8), .POLY_WIDTH(8), .POLY(64'h07), .INIT(64'h0),
    .REFLECT(1'b0), .XOR_OUT(64'h0)
  ) u_dut1 (
    .clk(clk), .rst(rst), .s_data_i(sd[1][7:0]), .s_keep_i(sk[1][0]), .s_last_i(sl[1]),
    .s_valid_i(sv[1]), .s_ready_o(sr_v[1]), .m_crc_o(crc1), .m_err_o(err_v[1]),
    .m_valid_o(val_v[1]), .m_ready_i(mr[1])
`ifdef CRC_CHECK_EN
    , .m_match_o(mat_v[1])
`endif
  );

  crc_stream #(
    .DATA_WIDTH(32), .POLY_WIDTH(16), .POLY(64'h1021), .INIT(64'hFFFF),
    .REFLECT(1'b0), .XOR_OUT(64'h0)
  ) u_dut2 (
    .clk(clk), .rst(rst), .s_data_i(sd[2]), .s_keep_i(sk[2]), .s_last_i(sl[2]),
    .s_valid_i(sv[2]), .s_ready_o(sr_v[2]), .m_crc_o(crc2), .m_err_o(err_v[2]),
    .m_valid_o(val_v[2]), .m_ready_i(mr[2])
`ifdef CRC_CHECK_EN
    , .m_match_o(mat_v[2])
`endif
  );

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %h, expected %h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  // Textbook bitwise CRC: reflected variants shift right with the mirrored
  // polynomial, normal variants shift left.
  function automatic logic [63:0] rev(input logic [63:0] v, input int unsigned w);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < w; i++) r[i] = v[w-1-i];
    return r;
  endfunction

  function automatic logic [31:0] ref_crc(input int d, input bq_t b);
    int unsigned w;
    logic [63:0] mask, c, pr;
    w    = CW[d];
    mask = (64'd1 << w) - 64'd1;
    if (CREF[d]) begin
      pr = rev(CPOLY[d], w);
      c  = rev(CINIT[d], w);
      foreach (b[i]) begin
        c ^= 64'(b[i]);
        for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ pr) : (c >> 1);
      end
    end else begin
      c = CINIT[d];
      foreach (b[i]) begin
        c ^= 64'(b[i]) << (w - 8);
        for (int j = 0; j < 8; j++) c = c[w-1] ? (((c << 1) ^ CPOLY[d]) & mask) : ((c << 1) & mask);
      end
    end
    return 32'((c ^ CXOR[d]) & mask);
  endfunction

  function automatic exp_t mk_exp(input int d, input logic [31:0] crc, input logic err);
    exp_t e;
    e.crc   = crc;
    e.err   = err;
    e.match = (crc == CRES[d]);
    e.cyc   = 0;
    return e;
  endfunction

  task automatic idle(input int d);
    sv[d] = 1'b0;
    sd[d] = $urandom;
    sk[d] = 4'($urandom);
    sl[d] = 1'($urandom);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic beat(input int d, input logic [31:0] data, input logic [3:0] keep,
                      input logic last, input exp_t e);
    int   n;
    exp_t ec;
    n = 0;
    sd[d] = data;
    sk[d] = keep;
    sl[d] = last;
    sv[d] = 1'b1;
    while (!sr_v[d] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("ready_timeout", d, 0, 1);
    if (last) begin
      ec     = e;
      ec.cyc = cyc;
      expq[d].push_back(ec);
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input int d, input wq_t dq, input kq_t kq, input exp_t e, input int gap_pct);
    for (int i = 0; i < dq.size(); i++) begin
      while ($urandom_range(0, 99) < gap_pct) idle(d);
      beat(d, dq[i], kq[i], i == dq.size() - 1, e);
    end
    sv[d] = 1'b0;
  endtask

  task automatic rand_frame(input int d, input int bad_pct);
    wq_t         dq;
    kq_t         kq;
    bq_t         bq;
    int          nbeats;
    int unsigned nb;
    logic        err, last;
    logic [3:0]  full, keep;
    logic [31:0] data;
    nb     = CNB[d];
    full   = 4'((1 << nb) - 1);
    nbeats = $urandom_range(1, 4);
    err    = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      data = $urandom;
      last = (i == nbeats - 1);
      keep = last ? 4'((1 << $urandom_range(0, nb)) - 1) : full;
      if ($urandom_range(0, 99) < bad_pct) keep = 4'($urandom_range(0, 32'(full)));
      if (!last) err |= (keep != full);
      else       err |= (keep != 4'((1 << $countones(keep)) - 1));
      for (int k = 0; k < int'(nb); k++) if (keep[k]) bq.push_back(data[8*k +: 8]);
      dq.push_back(data);
      kq.push_back(keep);
    end
    run_frame(d, dq, kq, mk_exp(d, ref_crc(d, bq), err), 25);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq[0].size() + expq[1].size() + expq[2].size()) != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("drain_timeout", 0, 0, 1);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      sd[d] = '0; sk[d] = '0; sl[d] = 1'b0; sv[d] = 1'b0;
      mr[d] = 1'b0; hold_low[d] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) mr[d] = hold_low[d] ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Scoreboard monitor: compares every presented result against the queue
  // head, pops on handshake, and checks the one-cycle bubble afterwards.
  logic pv  [3] = '{1'b0, 1'b0, 1'b0};
  logic phs [3] = '{1'b0, 1'b0, 1'b0};
  always @(negedge clk) begin : mon
    exp_t e;
    logic hs;
    for (int d = 0; d < 3; d++) begin
      hs = 1'b0;
      if (rst) begin
        pv[d]  = 1'b0;
        phs[d] = 1'b0;
      end else begin
        if (phs[d]) chk("post_handshake_ready_valid", d, {62'h0, sr_v[d], val_v[d]}, 64'h2);
        if (val_v[d]) begin
          if (expq[d].size() == 0) begin
            chk("unexpected_valid", d, 1, 0);
          end else begin
            e = expq[d][0];
            chk("crc", d, crc_v[d], e.crc);
            chk("err", d, err_v[d], e.err);
`ifdef CRC_CHECK_EN
            chk("match", d, mat_v[d], e.match);
`endif
            chk("s_ready_in_hold", d, sr_v[d], 0);
            if (!pv[d]) chk("latency", d, cyc, e.cyc + 1);
            if (mr[d]) begin
              void'(expq[d].pop_front());
              hs = 1'b1;
            end
          end
        end
        pv[d]  = val_v[d];
        phs[d] = hs;
      end
    end
  end

  initial begin : main
    wq_t  dq;
    kq_t  kq;
    exp_t e;
    int   n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_valid", d, val_v[d], 0);
      chk("reset_crc", d, crc_v[d], 0);
      chk("reset_err", d, err_v[d], 0);
      chk("reset_ready", d, sr_v[d], 0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk("ready_after_reset", d, sr_v[d], 1);

    // "123456789" on each configuration
    dq = '{32'h34333231, 32'h38373635, 32'h00000039};
    kq = '{4'hF, 4'hF, 4'h1};
    run_frame(0, dq, kq, mk_exp(0, 32'hCBF43926, 1'b0), 0);
    run_frame(1, '{32'h31, 32'h32, 32'h33, 32'h34, 32'h35, 32'h36, 32'h37, 32'h38, 32'h39},
              '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1}, mk_exp(1, 32'hF4, 1'b0), 20);
    run_frame(1, '{32'hAB}, '{4'h1}, mk_exp(1, 32'h58, 1'b0), 0);
    drain();

    // CRC-16 result held with m_ready_i low
    hold_low[2] = 1'b1;
    run_frame(2, dq, kq, mk_exp(2, 32'h29B1, 1'b0), 0);
    repeat (6) begin
      chk("hold_valid", 2, val_v[2], 1);
      chk("hold_ready", 2, sr_v[2], 0);
      @(negedge clk);
    end
    hold_low[2] = 1'b0;
    drain();

    // Illegal keep on a non-last beat, then a clean frame
    run_frame(0, '{32'h34333231, 32'h00000039}, '{4'h3, 4'h1},
              mk_exp(0, ref_crc(0, '{8'h31, 8'h32, 8'h39}), 1'b1), 0);
    run_frame(0, dq, kq, mk_exp(0, 32'hCBF43926, 1'b0), 10);
    // Non-contiguous keep on the last beat
    run_frame(0, '{32'h34333231}, '{4'h5},
              mk_exp(0, ref_crc(0, '{8'h31, 8'h33}), 1'b1), 0);
    drain();

    // Reset mid-frame discards the partial frame
    e = mk_exp(0, 0, 0);
    beat(0, 32'h34333231, 4'hF, 1'b0, e);
    sv[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("ready_during_reset", 0, sr_v[0], 0);
    rst = 1'b0;
    @(negedge clk);
    run_frame(0, dq, kq, mk_exp(0, 32'hCBF43926, 1'b0), 0);
    // Zero-byte frame
    run_frame(0, '{32'hDEADBEEF}, '{4'h0}, mk_exp(0, 32'h00000000, 1'b0), 0);
    drain();

    // Reset while a result is held
    hold_low[0] = 1'b1;
    run_frame(0, dq, kq, mk_exp(0, 32'hCBF43926, 1'b0), 0);
    n = 0;
    while (!val_v[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("hold_timeout", 0, 0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_in_hold_valid", 0, val_v[0], 0);
    chk("reset_in_hold_crc", 0, crc_v[0], 0);
    chk("reset_in_hold_ready", 0, sr_v[0], 0);
    expq[0].delete();
    rst = 1'b0;
    hold_low[0] = 1'b0;
    @(negedge clk);

    // Frame carrying its own CRC yields the residue; one flipped bit does not
    run_frame(0, '{32'h34333231, 32'h38373635, 32'hF4392639, 32'h000000CB},
              '{4'hF, 4'hF, 4'hF, 4'h1}, mk_exp(0, 32'h2144DF1C, 1'b0), 10);
    e = mk_exp(0, ref_crc(0, '{8'h30, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                               8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB}), 1'b0);
    e.match = 1'b0;
    run_frame(0, '{32'h34333230, 32'h38373635, 32'hF4392639, 32'h000000CB},
              '{4'hF, 4'hF, 4'hF, 4'h1}, e, 10);
    drain();

    // Randomised frames against the reference model
    for (int d = 0; d < 3; d++) begin
      for (int f = 0; f < 25; f++) rand_frame(d, 15);
    end
    drain();
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/crc_stream.md
Name: crc_stream

Overview:
- Parametrised, frame-based CRC engine; successor to generic_crc.
- Accepts a multi-beat byte stream with valid/ready handshake, per-byte keep and end-of-frame marker.
- Folds up to DATA_WIDTH/8 bytes per cycle into the CRC register.
- Presents the final checksum on a held output handshake; sits between packet datapaths and framing/check logic.

Parameters:
- DATA_WIDTH, 32: beat width in bits; multiple of 8, range 8..128.
- POLY_WIDTH, 32: CRC width in bits, 8..64.
- POLY, 32'h04C11DB7: generator polynomial, normal (non-reflected) form, implicit top bit.
- INIT, 32'hFFFFFFFF: register value at frame start.
- REFLECT, 1: 1 = reflect input bytes and output CRC (LSB-first); 0 = MSB-first.
- XOR_OUT, 32'hFFFFFFFF: XORed into the output CRC.
- RESIDUE, 32'h2144DF1C: expected output for a frame with its CRC appended; used only with CRC_CHECK_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_data_i  in  DATA_WIDTH  input beat; byte k = bits [8k+7:8k]; byte 0 is processed first
- s_keep_i  in  DATA_WIDTH/8  byte valid mask
- s_last_i  in  1  last beat of frame
- s_valid_i  in  1  beat valid
- s_ready_o  out  1  beat accepted when s_valid_i && s_ready_o
- m_crc_o  out  POLY_WIDTH  final CRC, reflected and XOR_OUT applied
- m_err_o  out  1  illegal keep pattern seen in this frame
- m_valid_o  out  1  result valid
- m_ready_i  in  1  result consumed when m_valid_o && m_ready_i

Behaviour:
- FSM states: ACC (idle or mid-frame) and HOLD (result presented).
- ACC: s_ready_o = 1.
  - Each accepted beat updates crc_q over its kept bytes, in byte order 0..N-1, within one cycle (unrolled chain).
  - Bytes with keep = 0 are skipped.
- Beat accepted with s_last_i = 1:
  - Next cycle: state HOLD, m_valid_o = 1.
  - m_crc_o = (REFLECT ? reverse(crc_next) : crc_next) ^ XOR_OUT, registered.
  - Latency: last beat accepted at cycle N gives m_valid_o at N+1.
- HOLD:
  - s_ready_o = 0.
  - m_crc_o and m_err_o are held stable until m_ready_i.
  - On handshake: return to ACC, crc_q = INIT, err cleared. The earliest next accepted beat is in the cycle after the handshake (one-cycle bubble).
- Keep rules:
  - Non-last beats must have all-ones keep.
  - The last beat must be LSB-contiguous (0..0111..1); all-zero keep on the last beat is legal and adds no bytes.
  - A violation sets sticky err for the frame. The kept bytes are still processed; the frame still completes normally.
- Zero-byte frame (single last beat, keep = 0): result = finalised INIT.
- Beats with s_valid_i = 0 have no effect; mid-frame gaps of any length are allowed.
- Reset, asserted in any state including mid-frame or HOLD:
  - Next edge: state ACC, crc_q = INIT, err = 0, m_valid_o = 0, m_crc_o = 0, m_err_o = 0.
  - s_ready_o is forced 0 while rst is high.
  - The partial frame is discarded.
- Width rule: all CRC arithmetic is done in POLY_WIDTH bits; parameters are truncated to POLY_WIDTH.

Optional Feature:
- Macro CRC_CHECK_EN.
- Defined: adds output m_match_o (1 bit, reset 0), registered with m_crc_o: m_match_o = (m_crc_o == RESIDUE). It is valid and held under the same m_valid_o handshake. This supports receive-side checking of frames that carry their CRC.
- Undefined: the port and comparator are absent; RESIDUE is unused.

Decomposition:
- Package crc_stream_pkg:
  - state_t enum {ACC, HOLD}
  - DATA/POLY width limit constants
  - bit-reverse function
  - keep-legality function (contiguity check)
- Sub-module crc_byte_step: combinational, parametrised by POLY_WIDTH/POLY/REFLECT; crc_in + byte -> crc_out. crc_stream instantiates a chain of DATA_WIDTH/8 of these, with a keep-controlled bypass per stage.

Test Plan:
- CRC-32 defaults, DATA_WIDTH=32: beats 0x34333231, 0x38373635 (keep 1111), then 0x00000039 keep 0001 last ("123456789") -> m_crc_o = 0xCBF43926, m_err_o = 0, m_valid_o one cycle after last.
- CRC-8 (POLY_WIDTH 8, POLY 8'h07, INIT 0, REFLECT 0, XOR_OUT 0), DATA_WIDTH=8: nine single-byte beats "123456789" -> 0xF4. Single beat 0xAB -> 0x58.
- CRC-16/CCITT-FALSE (16'h1021, INIT FFFF, REFLECT 0, XOR_OUT 0), DATA_WIDTH=32: same beats as the first scenario -> 0x29B1. Hold m_ready_i low 5 cycles -> result stable, s_ready_o = 0 throughout.
- Illegal keep: CRC-32 config; non-last beat with keep 0011 -> frame completes, m_err_o = 1. The next legal frame reports m_err_o = 0.
- Reset mid-frame after one beat, then full "123456789" frame -> 0xCBF43926. Zero-byte frame (last, keep 0) -> 0x00000000.
- CRC_CHECK_EN: CRC-32 frame "123456789" followed by bytes 26 39 F4 CB -> m_crc_o = 0x2144DF1C, m_match_o = 1. Corrupt one bit -> m_match_o = 0.
